// File: rtl/fetch_pkg.sv
// Shared encodings for the instruction-fetch unit: processor states and
// the next-PC source selector.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_HALT  = 2'b01,
        ST_WAIT  = 2'b10,
        ST_DEBUG = 2'b11
    } state_e;

    typedef enum logic [2:0] {
        SRC_INC  = 3'd0,
        SRC_BR   = 3'd1,
        SRC_JMP  = 3'd2,
        SRC_CALL = 3'd3,
        SRC_RET  = 3'd4
    } src_e;

    // The fetch unit may only move forward in the run state.
    function automatic logic is_run(input logic [1:0] st);
        return (st == ST_RUN);
    endfunction

endpackage

// File: rtl/ret_addr_stack.sv
// Circular return-address stack. When it is full, a push overwrites the
// oldest entry, because the write pointer wraps onto that entry.
module ret_addr_stack
    import fetch_pkg::*;
#(
    parameter int PC_W      = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [PC_W-1:0]              data_i,
    output logic [PC_W-1:0]              top_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(RAS_DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(RAS_DEPTH - 1);

    logic [PC_W-1:0]  mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d, top_idx_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign full_o  = (cnt_q == CNT_W'(RAS_DEPTH));
    assign empty_o = (cnt_q == CNT_W'(0));
    assign count_o = cnt_q;
    assign top_o   = mem_q[top_idx_s];

    // Pointer and occupancy update; push takes precedence over pop.
    always_comb begin
        top_idx_s = (wptr_q == PTR_W'(0)) ? LAST_IDX : (wptr_q - PTR_W'(1));
        wptr_d    = wptr_q;
        cnt_d     = cnt_q;
        if (push_i) begin
            wptr_d = (wptr_q == LAST_IDX) ? PTR_W'(0) : (wptr_q + PTR_W'(1));
            if (full_o) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop_i && !empty_o) begin
            wptr_d = top_idx_s;
            cnt_d  = cnt_q - CNT_W'(1);
        end else begin
            wptr_d = wptr_q;
            cnt_d  = cnt_q;
        end
    end

    // Stack storage and pointers; reset discards every entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= PTR_W'(0);
            cnt_q  <= CNT_W'(0);
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem_q[i] <= PC_W'(0);
            end
        end else begin
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
            if (push_i) begin
                mem_q[wptr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_ras.sv
// Program-counter generator with branch/jump/call/return selection and a
// return-address stack carrying sticky overflow/underflow flags.
module instr_fetch_ras
    import fetch_pkg::*;
#(
    parameter int PC_W      = 16,
    parameter int DST_W     = 8,
    parameter int RAS_DEPTH = 4,
    parameter int RESET_PC  = 0
) (
    input  logic                           CLK,
    input  logic                           reset_n,
    input  logic [1:0]                     state_ctrl,
    input  logic                           stall,
    input  logic                           br_ctrl,
    input  logic                           jmp_ctrl,
    input  logic                           call_ctrl,
    input  logic                           ret_ctrl,
    input  logic                           rel_mode,
    input  logic                           accdata_in,
    input  logic [DST_W-1:0]               dst_in,
    output logic [PC_W-1:0]                instr_addr,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           ras_overflow,
    output logic                           ras_underflow
);

    logic [PC_W-1:0] pc_q, pc_d, pc_inc_s, target_s, ras_top_s;
    logic            ovf_q, ovf_d, unf_q, unf_d;
    logic            advance_s, taken_s, push_s, pop_s, ras_full_s, ras_empty_s;
    src_e            src_s;

    assign advance_s = is_run(state_ctrl) && !stall;
    // Identity compare so an unknown condition never counts as taken.
    assign taken_s   = br_ctrl && (accdata_in === 1'b1);
    assign pc_inc_s  = pc_q + PC_W'(1);

    // Branch target: page-absolute or signed offset from the incremented PC.
    always_comb begin
        if (rel_mode) begin
            target_s = pc_inc_s + {{(PC_W-DST_W){dst_in[DST_W-1]}}, dst_in};
        end else begin
            target_s = {pc_inc_s[PC_W-1:DST_W], dst_in};
        end
    end

    // Fixed-priority source select; losers have no side effects.
    always_comb begin
        src_s = SRC_INC;
        if (ret_ctrl) begin
            src_s = SRC_RET;
        end else if (call_ctrl) begin
            src_s = SRC_CALL;
        end else if (jmp_ctrl) begin
            src_s = SRC_JMP;
        end else if (taken_s) begin
            src_s = SRC_BR;
        end else begin
            src_s = SRC_INC;
        end
    end

    // Next PC, stack strobes and sticky flag updates.
    always_comb begin
        pc_d   = pc_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        push_s = 1'b0;
        pop_s  = 1'b0;
        if (advance_s) begin
            case (src_s)
                SRC_RET: begin
                    pop_s = !ras_empty_s;
                    pc_d  = ras_empty_s ? pc_inc_s : ras_top_s;
                    unf_d = unf_q | ras_empty_s;
                end
                SRC_CALL: begin
                    push_s = 1'b1;
                    pc_d   = target_s;
                    ovf_d  = ovf_q | ras_full_s;
                end
                SRC_JMP, SRC_BR: pc_d = target_s;
                SRC_INC:         pc_d = pc_inc_s;
                default:         pc_d = pc_inc_s;
            endcase
        end else begin
            pc_d = pc_q;
        end
    end

    // PC and flag registers.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            pc_q  <= PC_W'(RESET_PC);
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    ret_addr_stack #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i   (CLK),
        .rst_ni  (reset_n),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .data_i  (pc_inc_s),
        .top_o   (ras_top_s),
        .full_o  (ras_full_s),
        .empty_o (ras_empty_s),
        .count_o (ras_count)
    );

    assign instr_addr    = pc_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule

// File: tb/tb_instr_fetch_ras.sv
// Directed self-checking bench for instr_fetch_ras with default parameters.
module tb_instr_fetch_ras;

    logic        CLK = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  state_ctrl = 2'b00;
    logic        stall = 1'b0, br_ctrl = 1'b0, jmp_ctrl = 1'b0;
    logic        call_ctrl = 1'b0, ret_ctrl = 1'b0, rel_mode = 1'b0;
    logic        accdata_in = 1'b0;
    logic [7:0]  dst_in = 8'h00;
    logic [15:0] instr_addr;
    logic [2:0]  ras_count;
    logic        ras_overflow, ras_underflow;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] model_pc = 16'h0000;

    instr_fetch_ras dut (
        .CLK           (CLK),
        .reset_n       (reset_n),
        .state_ctrl    (state_ctrl),
        .stall         (stall),
        .br_ctrl       (br_ctrl),
        .jmp_ctrl      (jmp_ctrl),
        .call_ctrl     (call_ctrl),
        .ret_ctrl      (ret_ctrl),
        .rel_mode      (rel_mode),
        .accdata_in    (accdata_in),
        .dst_in        (dst_in),
        .instr_addr    (instr_addr),
        .ras_count     (ras_count),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_ctrl();
        state_ctrl = 2'b00; stall = 1'b0; br_ctrl = 1'b0; jmp_ctrl = 1'b0;
        call_ctrl = 1'b0; ret_ctrl = 1'b0; rel_mode = 1'b0;
        accdata_in = 1'b0; dst_in = 8'h00;
    endtask

    task automatic do_reset();
        clear_ctrl();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        model_pc = 16'h0000;
    endtask

    // Reach an address with jumps: page-absolute when possible, else relative hops.
    task automatic goto_pc(input logic [15:0] t);
        logic [15:0] inc, d;
        int sd;
        for (int i = 0; i < 64 && model_pc != t; i++) begin
            inc = model_pc + 16'd1;
            jmp_ctrl = 1'b1;
            if (inc[15:8] == t[15:8]) begin
                rel_mode = 1'b0; dst_in = t[7:0]; model_pc = t;
            end else begin
                d = t - inc;
                sd = int'($signed(d));
                if (sd > 127) sd = 127;
                else if (sd < -128) sd = -128;
                rel_mode = 1'b1; dst_in = sd[7:0];
                model_pc = inc + 16'(sd);
            end
            step();
        end
        clear_ctrl();
        checks++;
        if (instr_addr !== t) begin
            failures++;
            $display("FAIL goto_pc: instr_addr=%h expected=%h", instr_addr, t);
        end
    endtask

    task automatic test_reset();
        clear_ctrl();
        reset_n = 1'b0;
        #3;
        checks++;
        if (instr_addr !== 16'h0000 || ras_count !== 3'd0 || ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: pc=%h cnt=%0d ovf=%b unf=%b expected 0000/0/0/0",
                     instr_addr, ras_count, ras_overflow, ras_underflow);
        end
        step();
        reset_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (instr_addr !== 16'(i)) begin
                failures++;
                $display("FAIL run_seq: instr_addr=%h expected=%h", instr_addr, 16'(i));
            end
        end
        model_pc = 16'h0004;
    endtask

    task automatic test_branch();
        goto_pc(16'h0104);
        br_ctrl = 1'b1; accdata_in = 1'b1; rel_mode = 1'b0; dst_in = 8'h20;
        step(); clear_ctrl();
        checks++;
        if (instr_addr !== 16'h0120) begin
            failures++;
            $display("FAIL br_taken: instr_addr=%h expected=0120", instr_addr);
        end
        model_pc = 16'h0120;
        goto_pc(16'h0104);
        br_ctrl = 1'b1; accdata_in = 1'bx; rel_mode = 1'b0; dst_in = 8'h20;
        step(); clear_ctrl();
        checks++;
        if (instr_addr !== 16'h0105) begin
            failures++;
            $display("FAIL br_x_cond: instr_addr=%h expected=0105", instr_addr);
        end
        model_pc = 16'h0105;
    endtask

    task automatic test_jump_wrap();
        goto_pc(16'h0010);
        jmp_ctrl = 1'b1; rel_mode = 1'b1; dst_in = 8'hF0;
        step(); clear_ctrl();
        checks++;
        if (instr_addr !== 16'h0001) begin
            failures++;
            $display("FAIL jmp_rel_neg: instr_addr=%h expected=0001", instr_addr);
        end
        model_pc = 16'h0001;
        goto_pc(16'hFFFF);
        step();
        checks++;
        if (instr_addr !== 16'h0000) begin
            failures++;
            $display("FAIL pc_wrap: instr_addr=%h expected=0000", instr_addr);
        end
        model_pc = 16'h0000;
    endtask

    task automatic test_ras_overflow();
        logic [15:0] exp_ret [4];
        exp_ret[0] = 16'h0041; exp_ret[1] = 16'h0031;
        exp_ret[2] = 16'h0021; exp_ret[3] = 16'h0011;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            call_ctrl = 1'b1; rel_mode = 1'b0; dst_in = 8'(i * 16);
            step(); clear_ctrl();
            checks++;
            if (instr_addr !== 16'(i * 16) || ras_count !== ((i > 4) ? 3'd4 : 3'(i))
                || ras_overflow !== (i == 5)) begin
                failures++;
                $display("FAIL call_%0d: pc=%h cnt=%0d ovf=%b", i, instr_addr, ras_count, ras_overflow);
            end
        end
        for (int i = 0; i < 4; i++) begin
            ret_ctrl = 1'b1;
            step(); clear_ctrl();
            checks++;
            if (instr_addr !== exp_ret[i] || ras_count !== 3'(3 - i) || ras_overflow !== 1'b1) begin
                failures++;
                $display("FAIL ret_%0d: pc=%h cnt=%0d ovf=%b expected pc=%h cnt=%0d",
                         i, instr_addr, ras_count, ras_overflow, exp_ret[i], 3 - i);
            end
        end
        model_pc = 16'h0011;
    endtask

    task automatic test_underflow_priority();
        do_reset();
        goto_pc(16'h0030);
        ret_ctrl = 1'b1;
        step(); clear_ctrl();
        checks++;
        if (instr_addr !== 16'h0031 || ras_underflow !== 1'b1 || ras_count !== 3'd0) begin
            failures++;
            $display("FAIL ret_empty: pc=%h unf=%b cnt=%0d expected 0031/1/0", instr_addr, ras_underflow, ras_count);
        end
        call_ctrl = 1'b1; dst_in = 8'h80;
        step(); clear_ctrl();
        call_ctrl = 1'b1; ret_ctrl = 1'b1; dst_in = 8'h90;
        step(); clear_ctrl();
        checks++;
        if (instr_addr !== 16'h0032 || ras_count !== 3'd0 || ras_overflow !== 1'b0) begin
            failures++;
            $display("FAIL call_ret_prio: pc=%h cnt=%0d expected 0032/0", instr_addr, ras_count);
        end
        model_pc = 16'h0032;
    endtask

    task automatic test_hold_and_midreset();
        call_ctrl = 1'b1; dst_in = 8'h40;
        step(); clear_ctrl();
        model_pc = 16'h0040;
        stall = 1'b1; jmp_ctrl = 1'b1; dst_in = 8'h77;
        step();
        checks++;
        if (instr_addr !== 16'h0040) begin
            failures++;
            $display("FAIL stall_hold: instr_addr=%h expected=0040", instr_addr);
        end
        clear_ctrl();
        state_ctrl = 2'b01; jmp_ctrl = 1'b1; dst_in = 8'h77;
        step();
        state_ctrl = 2'b10; ret_ctrl = 1'b1; jmp_ctrl = 1'b0;
        step();
        checks++;
        if (instr_addr !== 16'h0040 || ras_count !== 3'd1) begin
            failures++;
            $display("FAIL state_hold: pc=%h cnt=%0d expected 0040/1", instr_addr, ras_count);
        end
        clear_ctrl();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (instr_addr !== 16'h0000 || ras_count !== 3'd0 || ras_underflow !== 1'b0 || ras_overflow !== 1'b0) begin
            failures++;
            $display("FAIL midreset: pc=%h cnt=%0d ovf=%b unf=%b expected 0000/0/0/0",
                     instr_addr, ras_count, ras_overflow, ras_underflow);
        end
        step();
        reset_n = 1'b1;
        step();
        ret_ctrl = 1'b1;
        step(); clear_ctrl();
        checks++;
        if (instr_addr !== 16'h0002 || ras_underflow !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_ret: pc=%h unf=%b expected 0002/1", instr_addr, ras_underflow);
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_jump_wrap();
        test_ras_overflow();
        test_underflow_priority();
        test_hold_and_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ras.md
INSTR_FETCH_RAS -- requirements
Module: instr_fetch_ras

Interface
REQ-001 SHALL have parameter PC_W, default 16, program-counter width in bits.
REQ-002 SHALL have parameter DST_W, default 8, branch-operand width in bits (DST_W < PC_W).
REQ-003 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (>= 2).
REQ-004 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-005 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port state_ctrl  input  2  processor state; PC advances only in ST_RUN.
REQ-008 SHALL have port stall  input  1  holds PC and stack for the current cycle.
REQ-009 SHALL have port br_ctrl  input  1  conditional branch, taken when accdata_in = 1.
REQ-010 SHALL have port jmp_ctrl  input  1  unconditional jump.
REQ-011 SHALL have port call_ctrl  input  1  jump to target and push the return address.
REQ-012 SHALL have port ret_ctrl  input  1  pop the return address into the PC.
REQ-013 SHALL have port rel_mode  input  1  target mode: 0 = page-absolute, 1 = PC-relative.
REQ-014 SHALL have port accdata_in  input  1  branch condition; X or Z is treated as 0.
REQ-015 SHALL have port dst_in  input  DST_W  branch operand.
REQ-016 SHALL have port instr_addr  output  PC_W  current PC (registered).
REQ-017 SHALL have port ras_count  output  $clog2(RAS_DEPTH+1)  stack occupancy.
REQ-018 SHALL have port ras_overflow  output  1  sticky flag: a push was made while the stack was full.
REQ-019 SHALL have port ras_underflow  output  1  sticky flag: a pop was made while the stack was empty.

Function
REQ-020 SHALL define advance = (state_ctrl == ST_RUN) & ~stall; when advance = 0, PC, stack, count and flags hold.
REQ-021 SHALL compute pc_inc = instr_addr + 1, modulo 2^PC_W.
REQ-022 SHALL compute the target as {pc_inc[PC_W-1:DST_W], dst_in} when rel_mode = 0, and as pc_inc + sign-extended dst_in (modulo 2^PC_W) when rel_mode = 1.
REQ-023 SHALL select the next PC by priority ret_ctrl > call_ctrl > jmp_ctrl > taken branch > pc_inc; lower-priority controls asserted in the same cycle are ignored, including their stack effects.
REQ-024 SHALL, on a call, push pc_inc and load the target, with instr_addr updating one cycle after the control is sampled.
REQ-025 SHALL, on a call with the stack full, discard the oldest entry, keep ras_count = RAS_DEPTH, and set ras_overflow.
REQ-026 SHALL, on a ret with the stack non-empty, load the top entry into the PC and decrement ras_count.
REQ-027 SHALL, on a ret with the stack empty, load pc_inc, leave ras_count at 0, and set ras_underflow.
REQ-028 SHALL keep ras_overflow and ras_underflow set until reset.
REQ-029 SHALL have the target wrap at the PC_W boundary, with no error flag.

Reset
REQ-030 SHALL, while reset_n = 0, force instr_addr = RESET_PC, ras_count = 0, ras_overflow = 0 and ras_underflow = 0, regardless of CLK.
REQ-031 SHALL discard all stack contents on reset asserted mid-operation.
REQ-032 SHALL resume normally on the first rising CLK edge after reset_n deasserts.

Structure
REQ-033 SHALL place the ST_* state encoding (ST_RUN = 2'b00) and the next-PC source enum {SRC_INC, SRC_BR, SRC_JMP, SRC_CALL, SRC_RET} in package fetch_pkg.
REQ-034 SHALL implement the stack in one sub-module, ret_addr_stack, as a circular buffer with a push/pop/full/empty interface parametrised by PC_W and RAS_DEPTH.

Verification
REQ-035 SHALL verify: reset, then ST_RUN with no controls for 4 cycles -> instr_addr = 0, 1, 2, 3, 4.
REQ-036 SHALL verify: PC = 0x0104, br_ctrl = 1, accdata_in = 1, rel_mode = 0, dst_in = 0x20 -> PC = 0x0120; the same stimulus with accdata_in = X -> PC = 0x0105.
REQ-037 SHALL verify: PC = 0x0010, jmp_ctrl = 1, rel_mode = 1, dst_in = 0xF0 -> PC = 0x0001; at PC = 0xFFFF with no controls -> PC = 0x0000.
REQ-038 SHALL verify: 5 calls with RAS_DEPTH = 4, then 4 rets -> ras_overflow = 1, the returns pop entries 5, 4, 3, 2 in that order, and ras_count reaches 0.
REQ-039 SHALL verify: ret with the stack empty at PC = 0x0030 -> PC = 0x0031 and ras_underflow = 1; call_ctrl and ret_ctrl asserted together -> ret wins and no push occurs.
REQ-040 SHALL verify: stall = 1, or state_ctrl != ST_RUN, with jmp_ctrl = 1 -> PC unchanged; reset_n pulsed low mid-cycle -> PC = 0 and flags cleared immediately.
